// File: rtl/viterbi_decoder_param_if.sv
// Symbol-in / decoded-bit-out handshake bundle for viterbi_decoder_param.
interface viterbi_decoder_param_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_bits;
    logic       in_last;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;

    modport master (
        output in_valid, in_bits, in_last,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_bits, in_last,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/viterbi_decoder_param.sv
// Hard-decision rate-1/2 Viterbi decoder with elaboration-time K/G0/G1, register-exchange
// survivors of depth TB, and an in_last-triggered flush that drains the frame tail from state 0.
module viterbi_decoder_param #(
    parameter int unsigned  K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101,
    parameter int unsigned  TB = 15,
    parameter int unsigned  MW = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    viterbi_decoder_param_if.slave bus
);
    localparam int unsigned   S      = K - 1;
    localparam int unsigned   N      = 1 << S;
    localparam int unsigned   SW     = MW + 1;
    localparam int unsigned   CW     = $clog2(TB + 1);
    localparam int unsigned   IW     = $clog2(TB);
    localparam logic [MW-1:0] M_INIT = MW'(2 * K);
    localparam logic [SW-1:0] M_SAT  = SW'((1 << MW) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] metric_q [N];
    logic [MW-1:0] metric_d [N];
    logic [TB-1:0] surv_q   [N];
    logic [TB-1:0] surv_d   [N];
    logic [CW-1:0] cnt_q, cnt_d, cnt_new;
    logic [IW-1:0] idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_last_q, out_last_d;

    logic [SW-1:0] pm0      [N];
    logic [SW-1:0] pm1      [N];
    logic [SW-1:0] acs_raw  [N];
    logic [MW-1:0] acs_metric [N];
    logic [TB-1:0] acs_surv [N];
    logic [SW-1:0] min_raw;
    logic [S-1:0]  best;
    logic          accept;

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;

    // Old metric plus Hamming distance between the received symbol and the branch label.
    function automatic logic [SW-1:0] path_metric(input logic [MW-1:0] m,
                                                  input logic [K-1:0]  r,
                                                  input logic [1:0]    sym);
        logic [1:0] bm;
        bm = {1'b0, sym[1] ^ (^(r & G0))} + {1'b0, sym[0] ^ (^(r & G1))};
        return SW'(m) + SW'(bm);
    endfunction

    // Add-compare-select, normalisation and best-state search for the current symbol.
    always_comb begin
        for (int unsigned n = 0; n < N; n++) begin
            pm0[n] = path_metric(metric_q[S'(n << 1)],
                                 {1'(n >> (K - 2)), S'(n << 1)}, bus.in_bits);
            pm1[n] = path_metric(metric_q[S'((n << 1) | 1)],
                                 {1'(n >> (K - 2)), S'((n << 1) | 1)}, bus.in_bits);
            if (pm1[n] < pm0[n]) begin
                acs_raw[n]  = pm1[n];
                acs_surv[n] = {surv_q[S'((n << 1) | 1)][TB-2:0], 1'(n >> (K - 2))};
            end else begin
                acs_raw[n]  = pm0[n];
                acs_surv[n] = {surv_q[S'(n << 1)][TB-2:0], 1'(n >> (K - 2))};
            end
        end
        min_raw = acs_raw[0];
        for (int unsigned n = 1; n < N; n++) begin
            if (acs_raw[n] < min_raw) min_raw = acs_raw[n];
        end
        for (int unsigned n = 0; n < N; n++) begin
            acs_metric[n] = ((acs_raw[n] - min_raw) > M_SAT) ? MW'(M_SAT)
                                                             : MW'(acs_raw[n] - min_raw);
        end
        best = '0;
        for (int unsigned n = 1; n < N; n++) begin
            if (acs_metric[n] < acs_metric[best]) best = S'(n);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN: if (accept) state_d = bus.in_last ? FLUSH : RUN;
            FLUSH:     if (idx_q == '0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        metric_d    = metric_q;
        surv_d      = surv_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        in_ready_d  = (state_d != FLUSH);
        cnt_new     = (cnt_q == CW'(TB)) ? cnt_q : cnt_q + CW'(1);

        if (state_q == FLUSH) begin
            out_valid_d = 1'b1;
            out_bit_d   = surv_q[0][idx_q];
            out_last_d  = (idx_q == '0);
            if (idx_q == '0) begin
                // Back to a fresh trellis so the next frame needs no reset.
                for (int unsigned n = 0; n < N; n++) begin
                    metric_d[n] = (n == 0) ? '0 : M_INIT;
                    surv_d[n]   = '0;
                end
                cnt_d = '0;
            end else begin
                idx_d = idx_q - IW'(1);
            end
        end else if (accept) begin
            metric_d = acs_metric;
            surv_d   = acs_surv;
            cnt_d    = cnt_new;
            if (cnt_new >= CW'(TB)) begin
                out_valid_d = 1'b1;
                out_bit_d   = bus.in_last ? acs_surv[0][TB-1] : acs_surv[best][TB-1];
            end
            if (bus.in_last) begin
                idx_d = (cnt_new >= CW'(TB - 1)) ? IW'(TB - 2) : IW'(cnt_new - CW'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < N; n++) begin
                metric_q[n] <= (n == 0) ? '0 : M_INIT;
                surv_q[n]   <= '0;
            end
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            metric_q    <= metric_d;
            surv_q      <= surv_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Scoreboard bench: frames are convolutionally encoded in the bench, and the decoded stream
// is expected to equal the transmitted data plus tail zeros.
module tb_viterbi_decoder_param;
    typedef struct { bit b; bit l; } exp_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       vld  = 1'b0;
    logic       last = 1'b0;
    logic       sel  = 1'b0;
    logic [1:0] bits = 2'b00;
    logic       rdy;

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit       frm  [256];
    bit [1:0] flip [256];
    int   flen;
    int   kk, gg0, gg1, tbd;

    always #5 clk = ~clk;

    viterbi_decoder_param_if bus_a ();
    viterbi_decoder_param_if bus_b ();

    assign bus_a.in_valid = vld && !sel;
    assign bus_a.in_bits  = bits;
    assign bus_a.in_last  = last;
    assign bus_b.in_valid = vld && sel;
    assign bus_b.in_bits  = bits;
    assign bus_b.in_last  = last;
    assign rdy = sel ? bus_b.in_ready : bus_a.in_ready;

    viterbi_decoder_param dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    viterbi_decoder_param #(.K(5), .G0(5'b10011), .G1(5'b11101), .TB(25), .MW(6))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && bus_a.out_valid) begin
            if (q_a.size() == 0) check("a unexpected out_valid", 1, 0);
            else begin
                e = q_a.pop_front();
                check("a out_bit", int'(bus_a.out_bit), int'(e.b));
                check("a out_last", int'(bus_a.out_last), int'(e.l));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && bus_b.out_valid) begin
            if (q_b.size() == 0) check("b unexpected out_valid", 1, 0);
            else begin
                e = q_b.pop_front();
                check("b out_bit", int'(bus_b.out_bit), int'(e.b));
                check("b out_last", int'(bus_b.out_last), int'(e.l));
            end
        end
    end

    task automatic set_cfg(input logic s);
        sel = s;
        kk  = s ? 5 : 3;
        gg0 = s ? 'b10011 : 'b111;
        gg1 = s ? 'b11101 : 'b101;
        tbd = s ? 25 : 15;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        #1;
        check("a in_ready in reset", int'(bus_a.in_ready), 1);
        check("a out_valid in reset", int'(bus_a.out_valid), 0);
        check("a out_bit in reset", int'(bus_a.out_bit), 0);
        check("a out_last in reset", int'(bus_a.out_last), 0);
        check("b in_ready in reset", int'(bus_b.in_ready), 1);
        check("b out_valid in reset", int'(bus_b.out_valid), 0);
        q_a.delete();
        q_b.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // nd data bits followed by K-1 zero tail bits; no channel errors by default.
    task automatic make_frame(input int nd, input bit rnd, input logic [15:0] pat);
        for (int i = 0; i < 256; i++) flip[i] = 2'b00;
        for (int i = 0; i < nd; i++) frm[i] = rnd ? 1'($urandom) : pat[15 - i];
        flen = nd + kk - 1;
        for (int i = nd; i < flen; i++) frm[i] = 1'b0;
    endtask

    task automatic send_frame(input bit b2b, input int abort_at, input bit abort_flush);
        int   sreg = 0;
        int   full;
        int   stalls = 0;
        int   low = 0;
        exp_t e;
        for (int i = 0; i < flen; i++) begin
            e.b = frm[i];
            e.l = (i == flen - 1);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        for (int i = 0; i < flen; i++) begin
            full = (int'(frm[i]) << (kk - 1)) | sreg;
            sreg = full >> 1;
            vld  = 1'b1;
            bits = {1'($countones(full & gg0)), 1'($countones(full & gg1))} ^ flip[i];
            last = (i == flen - 1);
            while (!rdy && stalls < 200) begin
                stalls++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            if (i == abort_at) begin
                do_reset();
                return;
            end
        end
        // Garbage held valid during the flush must be ignored by the decoder.
        vld  = b2b;
        bits = 2'($urandom);
        last = 1'($urandom);
        while (!rdy && low < 500) begin
            if (abort_flush && low == 3) begin
                do_reset();
                return;
            end
            low++;
            @(posedge clk); #1;
        end
        vld = 1'b0;
        check("flush cycles with in_ready low", low, (flen < tbd - 1) ? flen : tbd - 1);
        check("in_ready stalls while sending", stalls, 0);
    endtask

    initial begin
        int          lens[7];
        logic [15:0] pat;
        pat  = 16'b1011001110001011;
        lens = '{0, 1, 12, 13, 14, 25, 40};
        set_cfg(1'b0);
        #1;
        do_reset();

        // Data 1 + tail -> symbols 11,10,11, flush 1,0,0.
        make_frame(1, 1'b0, 16'h8000);
        send_frame(1'b0, -1, 1'b0);

        make_frame(16, 1'b0, pat);
        send_frame(1'b0, -1, 1'b0);

        make_frame(16, 1'b0, pat);
        flip[4] = 2'b10;
        send_frame(1'b1, -1, 1'b0);

        make_frame(16, 1'b0, pat);
        flip[1]  = 2'b01;
        flip[11] = 2'b10;
        send_frame(1'b0, -1, 1'b0);

        foreach (lens[j]) begin
            make_frame(lens[j], 1'b1, '0);
            send_frame(1'($urandom), -1, 1'b0);
        end
        for (int j = 0; j < 6; j++) begin
            make_frame(int'($urandom_range(0, 40)), 1'b1, '0);
            send_frame(1'($urandom), -1, 1'b0);
        end

        make_frame(30, 1'b1, '0);
        send_frame(1'b0, 19, 1'b0);
        make_frame(16, 1'b0, pat);
        send_frame(1'b0, -1, 1'b0);

        make_frame(16, 1'b0, pat);
        send_frame(1'b1, -1, 1'b1);
        make_frame(20, 1'b1, '0);
        send_frame(1'b0, -1, 1'b0);

        set_cfg(1'b1);
        for (int j = 0; j < 3; j++) begin
            make_frame(64, 1'b1, '0);
            send_frame(j == 0, -1, 1'b0);
        end
        make_frame(3, 1'b1, '0);
        send_frame(1'b0, -1, 1'b0);

        for (int c = 0; c < 100 && (q_a.size() != 0 || q_b.size() != 0); c++) @(negedge clk);
        #1;
        check("a outputs still owed", q_a.size(), 0);
        check("b outputs still owed", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/viterbi_decoder_param.md
Name: viterbi_decoder_param

Overview:
Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes, with constraint length and generator polynomials set at elaboration. It uses register-exchange survivor storage and a fixed decision depth TB, and accepts one 2-bit code symbol per cycle. It sits after the channel/deframer and before the byte packer. It adds frame termination (in_last) with a tail flush, which the fixed K=3 decoder lacks.

Parameters:
K, 3, constraint length; legal 3..7; states N = 2^(K-1)
G0, 3'b111, generator for code bit c0 (K bits; bit K-1 = newest input)
G1, 3'b101, generator for code bit c1 (K bits)
TB, 15, decision depth in symbols; legal TB >= 2
MW, 6, path-metric width; 2^MW > 4*K required

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  in_bits/in_last valid
in_ready  out  1  decoder can accept a symbol
in_bits  in  2  received symbol {c0,c1}; c0 in bit 1
in_last  in  1  final symbol of frame; encoder has appended K-1 zero tail bits
out_valid  out  1  out_bit valid, single-cycle pulse; no backpressure
out_bit  out  1  decoded bit, oldest first
out_last  out  1  with out_valid, final decoded bit of frame

Behaviour:
- Reset (async, any state, mid-frame included): FSM=IDLE; metric[0]=0, metric[s!=0]=2*K; survivors=0; fill count=0; out_valid=0, out_bit=0, out_last=0, in_ready=1.
- Accept when in_valid && in_ready.
- Trellis:
  - State s is K-1 bits; input b; encoder reg {b,s}.
  - c0 = ^({b,s}&G0); c1 = ^({b,s}&G1).
  - Next state is {b, s[K-2:1]}.
- Branch metric: Hamming distance of in_bits to {c0,c1}, range 0..2.
- ACS per state n, once per accepted symbol:
  - Predecessors are {n[K-3:0],0} and {n[K-3:0],1}; b = n[K-2].
  - Pick the smaller of (metric + branch).
  - On a tie, the predecessor with LSB 0 wins.
- Normalisation: subtract the minimum new metric from all new metrics in the same cycle. Saturate at 2^MW-1.
- Survivor update: surv[n] <= {surv[pred][TB-2:0], b}, so bit TB-1 holds the oldest decision.
- Fill count cnt increments per accept and saturates at TB.
- FSM:
  - IDLE: in_ready=1. An accept goes to RUN, or to FLUSH if in_last is set.
  - RUN: in_ready=1.
    - Each accept with cnt_new >= TB registers out_valid=1. Latency is 1 cycle.
    - out_bit = new surv[best][TB-1]. best is the lowest new metric; ties go to the lowest index.
    - An accept with in_last uses state 0 instead of best, then goes to FLUSH.
  - FLUSH: in_ready=0; in_valid is ignored.
    - Emit from surv[0], one bit per cycle, from index min(cnt,TB-1)-1 down to index 0.
    - out_last=1 on the index-0 bit.
    - The flush length is min(N_frame, TB-1) bits.
    - Total output bits equals the total accepted symbols, including the K-1 tail bits.
    - After the last flush bit, go to IDLE and reinitialise metrics, survivors and cnt the same cycle.
- Boundary cases:
  - Single-symbol frame: 1 output bit, with out_last set.
  - cnt == TB at in_last: 1 bit is emitted in RUN, then TB-1 bits in FLUSH.
  - No output without a prior accept or flush.

Test Plan:
- Reset: assert rst mid-RUN and mid-FLUSH -> out_valid=0 and in_ready=1 immediately; next frame decodes as from fresh.
- Short frame, K=3, G=7/5 octal: symbols 11,10,11 with in_last on the 3rd -> no RUN output; FLUSH emits 1,0,0, out_last on the 3rd bit, in_ready=0 for 3 cycles.
- Error-free frame, defaults: data 1011001110001011 plus tail 00 (18 symbols) -> 4 bits in RUN, 14 in FLUSH; sequence equals data+00; out_last on the 18th.
- Error correction: same frame with one bit flipped in symbol 5, then 2 bits in symbols 2 and 12 -> output identical to the error-free case.
- Parameter sweep: K=5, G0=5'b10011, G1=5'b11101, TB=25; random 64-bit frame plus 4 tail bits, error-free -> exact match; in_ready stays 1 through RUN.
- Back-to-back frames: in_valid held high across FLUSH -> no accept during FLUSH; first symbol of frame 2 accepted in the cycle after out_last; frame 2 decodes correctly.
